child_resp_collector: RTL
=========================

# child_resp_collector

Fan-in collector that merges response streams from up to N child instances of a hierarchy node into one tagged output stream. It is the upward (child-to-parent) counterpart of a node's fan-out to its children. Round-robin arbitration over valid/ready source ports feeds a single registered output stage; each output word carries the index of its source.

## Interface
Parameters:
- N_SRC, 5, number of child source ports (2..16)
- DATA_W, 8, payload width per source
- CNT_W, 16, width of each per-source grant counter
- IDX_W, $clog2(N_SRC), source-index width (derived, not overridden)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- src_valid  in  N_SRC  per-source valid
- src_data  in  N_SRC*DATA_W  per-source payload; source i at bits [i*DATA_W +: DATA_W]
- src_ready  out  N_SRC  per-source ready; one-hot or zero
- out_valid  out  1  output word valid
- out_data  out  DATA_W  output payload
- out_src  out  IDX_W  index of the source that produced out_data
- out_ready  in  1  downstream accept
- grant_cnt  out  N_SRC*CNT_W  per-source accepted-word counters; source i at [i*CNT_W +: CNT_W]

## Operation
- Output stage: one register holding {out_data, out_src} plus a valid flag (out_valid).
- load_en = !out_valid || out_ready.
- Arbiter: when load_en is high, grant the first i with src_valid[i]=1, searching from rr_ptr upward and wrapping N_SRC-1 -> 0.
- src_ready[i] = load_en && grant==i. This is combinational from src_valid, rr_ptr, out_valid and out_ready.
- A transfer on source i occurs when src_valid[i] && src_ready[i].
- On a transfer:
  - the output register loads src_data[i] and i;
  - out_valid is set to 1;
  - rr_ptr becomes (i+1) mod N_SRC.
- When out_valid && out_ready and no source is valid, out_valid is cleared to 0.
- When no transfer occurs, rr_ptr holds.
- Sources must hold valid and data stable until accepted; the block never drops a word once it is accepted.
- Output holds data and src stable while out_valid && !out_ready.
- Simultaneous drain and load in the same cycle is legal and sustains one word per cycle.
- Fairness: a continuously valid source is granted within N_SRC transfers.

## Timing
- Reset values: out_valid=0, out_data=0, out_src=0, rr_ptr=0, all grant_cnt=0. src_ready is all-zero while rst_n=0.
- Latency: a source transfer in cycle T gives out_valid=1 with that word in cycle T+1.
- Throughput: 1 word/cycle when out_ready is held high.
- Backpressure: with out_valid=1 and out_ready=0, all src_ready are 0.
- Reset mid-operation: asynchronous assertion immediately clears out_valid, rr_ptr and the counters. The held word is discarded. Sources keep their own valid.
- No combinational path from src_valid to out_valid. There is a combinational path from out_ready to src_ready.

## Configuration
- Macro: CHILD_RESP_COLLECTOR_STATS_EN.
- Defined: grant_cnt[i] increments by 1 on each transfer from source i. It saturates at 2^CNT_W-1 and does not wrap.
- Undefined: the counters are not built and grant_cnt is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then src_valid=5'b00100 with src_data[2]=8'hA5 and out_ready=1 -> src_ready=5'b00100 in the same cycle. Next cycle: out_valid=1, out_data=A5, out_src=2, rr_ptr=3.
- All five sources valid continuously, out_ready=1, starting at rr_ptr=0 -> out_src sequence 0,1,2,3,4,0,1, one word per cycle, no bubbles.
- Word held with out_ready=0 for 4 cycles while sources 1 and 3 are valid -> out_data/out_src stable and src_ready=0 throughout. When out_ready=1, source 1 transfers in the same cycle and source 3 next.
- Wrap-around: rr_ptr=4, only sources 0 and 4 valid -> grant 4, then 0, then 4.
- rst_n pulsed low while out_valid=1 -> out_valid=0 immediately, without waiting for a clock edge. After release the first grant searches from index 0.
- With CHILD_RESP_COLLECTOR_STATS_EN and CNT_W=4: 20 transfers from source 1 -> grant_cnt[1]=15 (saturated), others 0. Without the macro, grant_cnt=0 throughout.

Source files
------------

// File: rtl/child_resp_collector.sv
// child_resp_collector: round-robin fan-in of child response streams into one registered, source-tagged output.
// Optional per-source saturating grant counters with CHILD_RESP_COLLECTOR_STATS_EN.
module child_resp_collector #(
  parameter int N_SRC = 5,
  parameter int DATA_W = 8,
  parameter int CNT_W = 16,
  localparam int IDX_W = $clog2(N_SRC)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_SRC-1:0]        src_valid,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic [N_SRC-1:0]        src_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic [IDX_W-1:0]        out_src,
  input  logic                    out_ready,
  output logic [N_SRC*CNT_W-1:0]  grant_cnt
);
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt;
  logic             load_en;
  logic             xfer;
  int               j;

  // Scan downward so the first valid index at or after rr_ptr is the last one written.
  always_comb begin
    gnt = '0;
    j = 0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= N_SRC) j = j - N_SRC;
      if (src_valid[j]) gnt = IDX_W'(j);
    end
  end

  // rst_n gates ready so no source sees an acceptance while the block is held in reset.
  assign load_en   = rst_n && (!out_valid || out_ready);
  assign xfer      = load_en && |src_valid;
  assign src_ready = xfer ? N_SRC'(1) << gnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= src_data[gnt*DATA_W +: DATA_W];
      out_src   <= gnt;
      rr_ptr    <= (gnt == IDX_W'(N_SRC - 1)) ? '0 : gnt + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef CHILD_RESP_COLLECTOR_STATS_EN
  for (genvar i = 0; i < N_SRC; i++) begin : g_cnt
    logic [CNT_W-1:0] c;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) c <= '0;
      else if (src_ready[i] && c != '1) c <= c + 1'b1;
    end
    assign grant_cnt[i*CNT_W +: CNT_W] = c;
  end
`else
  assign grant_cnt = '0;
`endif
endmodule
